// File: rtl/multicycle_control_fsm.sv
// Moore control FSM that sequences a multi-cycle RV32I-subset datapath.
// Ports: clk, rst (sync active-low), OP, Zero, MemReady in; datapath
// enables/selects, ALUOp, ImmSrc, IllegalOp out. Optional macro
// MULTICYCLE_PERF_EN adds CycleCount/InstrCount counters.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       OP,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             AdrSrc,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       ResultSrc,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       ImmSrc,
  output logic             IllegalOp
`ifdef MULTICYCLE_PERF_EN
  ,
  output logic [CNT_W-1:0] CycleCount,
  output logic [CNT_W-1:0] InstrCount
`endif
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    JAL      = 4'd8,
    ALUWB    = 4'd9,
    BEQ      = 4'd10
  } state_t;

  state_t     state;
  state_t     nxt;
  logic       pcupd;
  logic       branch;
  logic       adr;
  logic       mw;
  logic       irw;
  logic       rw;
  logic [1:0] rs;
  logic [1:0] sa;
  logic [1:0] sb;
  logic [1:0] aop;
  logic [1:0] imm;
  logic       ill;
  logic       done;

  always_comb begin
    nxt    = FETCH;
    pcupd  = 1'b0;
    branch = 1'b0;
    adr    = 1'b0;
    mw     = 1'b0;
    irw    = 1'b0;
    rw     = 1'b0;
    rs     = 2'b00;
    sa     = 2'b00;
    sb     = 2'b00;
    aop    = 2'b00;
    ill    = 1'b0;
    done   = 1'b0;
    unique case (state)
      FETCH: begin
        sb    = 2'b10;
        rs    = 2'b10;
        irw   = MemReady;
        pcupd = MemReady;
        nxt   = MemReady ? DECODE : FETCH;
      end
      DECODE: begin
        sa = 2'b01;
        sb = 2'b01;
        unique case (OP)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXECUTER;
          OP_I:         nxt = EXECUTEI;
          OP_JAL:       nxt = JAL;
          OP_BEQ:       nxt = BEQ;
          default: begin
            nxt  = FETCH;
            ill  = 1'b1;
            done = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        sa  = 2'b10;
        sb  = 2'b01;
        nxt = (OP == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adr = 1'b1;
        nxt = MemReady ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        rs   = 2'b01;
        rw   = 1'b1;
        done = 1'b1;
      end
      MEMWRITE: begin
        adr  = 1'b1;
        mw   = 1'b1;
        done = MemReady;
        nxt  = MemReady ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        sa  = 2'b10;
        aop = 2'b10;
        nxt = ALUWB;
      end
      EXECUTEI: begin
        sa  = 2'b10;
        sb  = 2'b01;
        aop = 2'b10;
        nxt = ALUWB;
      end
      JAL: begin
        sa    = 2'b01;
        sb    = 2'b10;
        pcupd = 1'b1;
        nxt   = ALUWB;
      end
      ALUWB: begin
        rw   = 1'b1;
        done = 1'b1;
      end
      BEQ: begin
        sa     = 2'b10;
        aop    = 2'b01;
        branch = 1'b1;
        done   = 1'b1;
      end
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    unique case (OP)
      OP_SW:   imm = 2'b01;
      OP_BEQ:  imm = 2'b10;
      OP_JAL:  imm = 2'b11;
      default: imm = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= FETCH;
    else      state <= nxt;
  end

  // Every output is held low combinationally while reset is asserted.
  assign PCWrite   = rst & (pcupd | (branch & Zero));
  assign AdrSrc    = rst & adr;
  assign MemWrite  = rst & mw;
  assign IRWrite   = rst & irw;
  assign RegWrite  = rst & rw;
  assign ResultSrc = {2{rst}} & rs;
  assign ALUSrcA   = {2{rst}} & sa;
  assign ALUSrcB   = {2{rst}} & sb;
  assign ALUOp     = {2{rst}} & aop;
  assign ImmSrc    = {2{rst}} & imm;
  assign IllegalOp = rst & ill;

`ifdef MULTICYCLE_PERF_EN
  logic [CNT_W-1:0] cyc;
  logic [CNT_W-1:0] ins;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc <= '0;
      ins <= '0;
    end else begin
      cyc <= cyc + 1'b1;
      if (done) ins <= ins + 1'b1;
    end
  end

  assign CycleCount = rst ? cyc : '0;
  assign InstrCount = rst ? ins : '0;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm: per-instruction
// expected cycle sequences built from instruction class and wait counts.
module tb_multicycle_control_fsm;

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RT  = 7'b0110011;
  localparam logic [6:0] IT  = 7'b0010011;
  localparam logic [6:0] JL  = 7'b1101111;
  localparam logic [6:0] BQ  = 7'b1100011;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  OP = '0;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b0;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, IllegalOp;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc;
`ifdef MULTICYCLE_PERF_EN
  logic [31:0] CycleCount, InstrCount;
`endif

  multicycle_control_fsm dut (
    .clk(clk), .rst(rst), .OP(OP), .Zero(Zero), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .ImmSrc(ImmSrc), .IllegalOp(IllegalOp)
`ifdef MULTICYCLE_PERF_EN
    , .CycleCount(CycleCount), .InstrCount(InstrCount)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        mr;
    logic        z;
    logic [6:0]  op;
    logic [15:0] exp;
    bit          last;
  } rec_t;

  rec_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          force_z = -1;
  logic [6:0]  cur_op;
  logic [15:0] obs;
  int          cyc_exp = 0;
  int          ins_exp = 0;

  assign obs = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUOp, ImmSrc, IllegalOp};

  function automatic logic rb();
    return logic'($urandom_range(1, 0));
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] op);
    if (op == SW) return 2'b01;
    if (op == BQ) return 2'b10;
    if (op == JL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic bit legal(input logic [6:0] op);
    return op == LW || op == SW || op == RT || op == IT ||
           op == JL || op == BQ;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic push(input logic mr, input logic z, input logic pcw,
                      input logic adr, input logic mw, input logic irw,
                      input logic rw, input logic [1:0] rs,
                      input logic [1:0] sa, input logic [1:0] sb,
                      input logic [1:0] aop, input logic ill,
                      input bit last);
    rec_t r;
    r.mr   = mr;
    r.z    = z;
    r.op   = cur_op;
    r.exp  = {pcw, adr, mw, irw, rw, rs, sa, sb, aop, imm_of(cur_op), ill};
    r.last = last;
    q.push_back(r);
  endtask

  task automatic alu_wb();
    push(rb(), rb(), 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction.
  task automatic gen(input logic [6:0] op, input int wf, input int wm);
    logic z;
    bit   il;
    cur_op = op;
    il = !legal(op);
    repeat (wf)
      push(0, rb(), 0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    push(1, rb(), 1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0);
    push(rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, il, il);
    if (op == LW || op == SW)
      push(rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0);
    if (op == LW) begin
      repeat (wm)
        push(0, rb(), 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      push(1, rb(), 0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      push(rb(), rb(), 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 2'b00, 0, 1);
    end
    if (op == SW) begin
      repeat (wm)
        push(0, rb(), 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0);
      push(1, rb(), 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1);
    end
    if (op == RT) begin
      push(rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0);
      alu_wb();
    end
    if (op == IT) begin
      push(rb(), rb(), 0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0);
      alu_wb();
    end
    if (op == JL) begin
      push(rb(), rb(), 1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0);
      alu_wb();
    end
    if (op == BQ) begin
      z = (force_z >= 0) ? logic'(force_z) : rb();
      push(rb(), z, z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 1);
    end
  endtask

  task automatic step(input string tag);
    rec_t r;
    r = q.pop_front();
    @(posedge clk);
    #1;
    rst      = 1'b1;
    MemReady = r.mr;
    Zero     = r.z;
    OP       = r.op;
    @(negedge clk);
    chk(tag, {16'h0, obs}, {16'h0, r.exp});
`ifdef MULTICYCLE_PERF_EN
    chk({tag, "_cyc"}, CycleCount, cyc_exp);
    chk({tag, "_ins"}, InstrCount, ins_exp);
    cyc_exp++;
    if (r.last) ins_exp++;
`endif
  endtask

  task automatic run(input string tag);
    while (q.size() > 0) step(tag);
  endtask

  task automatic do_reset(input int n, input string tag);
    repeat (n) begin
      @(posedge clk);
      #1;
      rst      = 1'b0;
      MemReady = rb();
      Zero     = rb();
      OP       = 7'($urandom);
      @(negedge clk);
      chk(tag, {16'h0, obs}, 32'h0);
`ifdef MULTICYCLE_PERF_EN
      chk({tag, "_cyc"}, CycleCount, 0);
      chk({tag, "_ins"}, InstrCount, 0);
`endif
    end
    q.delete();
    cyc_exp = 0;
    ins_exp = 0;
  endtask

  logic [6:0] ops[7];

  initial begin
    ops[0] = LW; ops[1] = SW; ops[2] = RT; ops[3] = IT;
    ops[4] = JL; ops[5] = BQ; ops[6] = 7'b1111111;

    do_reset(3, "reset0");
    gen(RT, 0, 0);
    run("rtype");
    gen(LW, 0, 2);
    run("lw_wait2");
    gen(SW, 0, 1);
    run("sw_wait1");
    force_z = 1;
    gen(BQ, 0, 0);
    run("beq_taken");
    force_z = 0;
    gen(BQ, 0, 0);
    run("beq_not");
    force_z = -1;
    gen(7'b1111111, 0, 0);
    run("illegal");
    gen(IT, 2, 0);
    run("itype_fwait");
    gen(JL, 0, 0);
    run("jal");

    // Reset while sitting in MEMWRITE must drop MemWrite at once.
    gen(SW, 0, 3);
    repeat (3) step("sw_pre");
    do_reset(3, "reset_memwrite");
    gen(LW, 1, 1);
    run("lw_after_rst");

    for (int k = 0; k < 6; k++) begin
      gen(ops[$urandom_range(6, 0)], $urandom_range(2, 0),
          $urandom_range(2, 0));
      repeat ($urandom_range(q.size() - 1, 0)) step("rnd_pre");
      do_reset(3, "reset_rnd");
    end

    for (int k = 0; k < 200; k++) begin
      if ($urandom_range(9, 0) == 0) cur_op = 7'($urandom);
      else cur_op = ops[$urandom_range(6, 0)];
      gen(cur_op, $urandom_range(2, 0), $urandom_range(3, 0));
      run("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Moore control FSM that sequences a multi-cycle RV32I-subset datapath (lw, sw, R-type, I-type ALU, beq, jal).
- Shares one ALU and one unified instruction/data memory across instruction phases.
- Sits beside the existing alu_decoder: this block produces ALUOp; alu_decoder turns ALUOp/funct3/funct7 into ALUControl.
- Memory accesses stall on a MemReady handshake.

Parameters:
- CNT_W, 32, width of the performance counters (used only with MULTICYCLE_PERF_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- OP  input  7  opcode field from the instruction register.
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory completes the current access this cycle.
- PCWrite  output  1  PC register enable.
- AdrSrc  output  1  memory address select: 0 = PC, 1 = Result.
- MemWrite  output  1  memory write strobe.
- IRWrite  output  1  instruction/OldPC register enable.
- RegWrite  output  1  register file write enable.
- ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
- ALUSrcA  output  2  00 = PC, 01 = OldPC, 10 = RD1.
- ALUSrcB  output  2  00 = RD2, 01 = ImmExt, 10 = constant 4.
- ALUOp  output  2  00 = add, 01 = sub, 10 = funct-decoded.
- ImmSrc  output  2  decoded from OP: I/lw 00, sw 01, beq 10, jal 11, other 00.
- IllegalOp  output  1  one-cycle pulse in DECODE on an unsupported OP.

Behaviour:
- Reset: single clock domain; reset is synchronous, active-low.
  - rst=0 at a rising edge: state <= FETCH.
  - While rst=0, all outputs are forced to 0 combinationally.
  - Reset mid-access (e.g. in MEMWRITE) drops MemWrite in the same cycle; no partial-state retention.
- State register: 4-bit. Outputs are decoded from state only, except:
  - IRWrite and PCWrite in FETCH (qualified by MemReady).
  - PCWrite in BEQ (qualified by Zero).
  - ImmSrc (from OP).
- Unlisted outputs are 0 in each state.
- PCWrite = PCUpdate | (Branch & Zero). PCUpdate and Branch are internal.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=MemReady, PCUpdate=MemReady.
  - MemReady=0: stay in FETCH (wait state, PC not advanced). MemReady=1: go to DECODE.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUOp=00 (precompute branch target).
  - Next state by OP: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1101111 -> JAL; 1100011 -> BEQ.
  - Any other OP -> FETCH with IllegalOp=1 for this cycle; the instruction is treated as a NOP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. OP=0000011 -> MEMREAD, else -> MEMWRITE.
- MEMREAD: AdrSrc=1, ResultSrc=00. Hold until MemReady=1, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, then go to FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite stays high until MemReady=1, then go to FETCH.
- EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10, then go to ALUWB.
- EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10, then go to ALUWB.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1, then go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, then go to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, then go to FETCH.
- Latency with zero wait states:
  - R/I-type and jal: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - Each cycle of MemReady=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- Unreachable state encodings go to FETCH on the next edge with all outputs 0.

Optional Feature:
- Macro: MULTICYCLE_PERF_EN.
- Defined: adds outputs CycleCount[CNT_W-1:0] and InstrCount[CNT_W-1:0], both 0 during reset.
  - CycleCount increments every cycle with rst=1.
  - InstrCount increments on every transition into FETCH from MEMWB, MEMWRITE, ALUWB, BEQ, or DECODE-illegal.
  - Both wrap modulo 2^CNT_W.
- Undefined: ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: hold rst=0 for 3 cycles in random state -> all outputs 0; after release, first cycle is FETCH with ALUSrcB=10, ResultSrc=10.
- R-type add, MemReady=1: OP=0110011 -> states FETCH, DECODE, EXECUTER, ALUWB; RegWrite=1 only in cycle 4; ALUOp=10 in cycle 3; back in FETCH at cycle 5.
- lw with MemReady low for 2 cycles in MEMREAD: OP=0000011 -> 7 cycles total; AdrSrc=1 for 3 cycles; RegWrite with ResultSrc=01 exactly once.
- sw with MemReady low for 1 cycle: OP=0100011 -> MemWrite=1 for 2 consecutive cycles, ImmSrc=01, RegWrite never set.
- beq: Zero=1 -> PCWrite=1 in BEQ, ALUOp=01. Zero=0 -> PCWrite=0. Both return to FETCH after 3 cycles.
- Illegal OP=1111111 -> IllegalOp pulses 1 cycle in DECODE, next state FETCH, no RegWrite/MemWrite. With MULTICYCLE_PERF_EN, InstrCount +1.
